// File: rtl/instr_buffer_pkg.sv
// Shared definitions for the instruction buffer: buffer size, index/count
// typedefs and the FETCH_PACKET layout passed between fetch and decode.
// `IBUF_SZ and `N may be overridden on the command line.
`ifndef IBUF_SZ
`define IBUF_SZ 16
`endif
`ifndef N
`define N 3
`endif

package instr_buffer_pkg;
  localparam int IBUF_SZ = `IBUF_SZ;
  localparam int IBUF_N  = `N;

  typedef logic [$clog2(IBUF_SZ)-1:0]   IBUF_IDX;
  typedef logic [$clog2(IBUF_SZ+1)-1:0] IBUF_COUNT;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } FETCH_PACKET;
endpackage

// File: rtl/instr_buffer.sv
// Circular FIFO of fetch packets between fetch and decode/dispatch.
// Accepts up to N packets per cycle as an all-or-nothing group, exposes the
// N oldest entries as a dispatch window, retires up to N per cycle, and
// empties completely on flush. Reset is synchronous, active-low.
// Optional: define IBUF_PERF_EN to add saturating performance counters.
module instr_buffer
  import instr_buffer_pkg::*;
#(
  parameter  int N     = IBUF_N,
  parameter  int DEPTH = IBUF_SZ,
  localparam int CW    = $clog2(N + 1),
  localparam int SW    = $clog2(DEPTH + 1),
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [CW-1:0]           fetch_count,
  input  FETCH_PACKET [N-1:0]     fetch_packets,
  output logic [SW-1:0]           free_slots,
  output logic                    fetch_accept,
  output FETCH_PACKET [N-1:0]     dispatch_window,
  output logic [CW-1:0]           window_valid_count,
  input  logic [CW-1:0]           dispatch_count
`ifdef IBUF_PERF_EN
  ,
  output logic [31:0]             perf_empty_cycles,
  output logic [31:0]             perf_full_stalls,
  output logic [31:0]             perf_dispatched
`endif
);

  FETCH_PACKET         mem [DEPTH];
  logic [IW-1:0]       head_q, head_d;
  logic [IW-1:0]       tail_q, tail_d;
  logic [SW-1:0]       count_q, count_d;
  logic [CW-1:0]       pop;
  logic                push_en;

  // Space is judged on registered occupancy only, so a same-cycle pop never
  // feeds back into the accept decision. An empty group is not an accept.
  assign free_slots         = SW'(DEPTH) - count_q;
  assign window_valid_count = (count_q < SW'(N)) ? CW'(count_q) : CW'(N);
  assign fetch_accept       = (fetch_count != '0) && (SW'(fetch_count) <= free_slots) && !flush;
  assign pop                = (dispatch_count < window_valid_count) ? dispatch_count : window_valid_count;
  assign push_en            = fetch_accept && reset;

  // Dispatch window: lane gi reads entry head+gi (wraps naturally), zero past valid count
  for (genvar gi = 0; gi < N; gi++) begin : g_window
    assign dispatch_window[gi] = (CW'(gi) < window_valid_count) ? mem[head_q + IW'(gi)] : '0;
  end

  // Next-state pointers and occupancy; flush discards everything in flight
  always_comb begin
    head_d  = head_q + IW'(pop);
    tail_d  = tail_q + (fetch_accept ? IW'(fetch_count) : '0);
    count_d = count_q + (fetch_accept ? SW'(fetch_count) : '0) - SW'(pop);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Entry array write: accepted lanes land at tail+j, possibly straddling the wrap
  always_ff @(posedge clock) begin
    if (push_en) begin
      for (int j = 0; j < N; j++) begin
        if (CW'(j) < fetch_count) begin
          mem[tail_q + IW'(j)] <= fetch_packets[j];
        end
      end
    end
  end

  // Pointer/count registers; reset overrides flush and traffic
  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

`ifdef IBUF_PERF_EN
  logic [32:0] disp_sum;
  assign disp_sum = {1'b0, perf_dispatched} + 33'(flush ? '0 : pop);

  // Saturating performance counters; cleared by reset only, not by flush
  always_ff @(posedge clock) begin
    if (!reset) begin
      perf_empty_cycles <= '0;
      perf_full_stalls  <= '0;
      perf_dispatched   <= '0;
    end else begin
      if (count_q == '0 && perf_empty_cycles != 32'hFFFF_FFFF)
        perf_empty_cycles <= perf_empty_cycles + 32'd1;
      if (fetch_count != '0 && !fetch_accept && !flush && perf_full_stalls != 32'hFFFF_FFFF)
        perf_full_stalls <= perf_full_stalls + 32'd1;
      perf_dispatched <= disp_sum[32] ? 32'hFFFF_FFFF : disp_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_instr_buffer.sv
// Directed bench for instr_buffer (N=3, DEPTH=16): reset, fill/full,
// wrap-around, simultaneous push/pop, over-request, flush and reset priority.
module tb_instr_buffer;
  import instr_buffer_pkg::*;

  localparam int N     = 3;
  localparam int DEPTH = 16;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               flush = 1'b0;
  logic [1:0]         fetch_count = '0;
  logic [1:0]         dispatch_count = '0;
  FETCH_PACKET [N-1:0] fetch_packets = '0;
  FETCH_PACKET [N-1:0] dispatch_window;
  logic [4:0]         free_slots;
  logic               fetch_accept;
  logic [1:0]         window_valid_count;
`ifdef IBUF_PERF_EN
  logic [31:0]        perf_empty_cycles, perf_full_stalls, perf_dispatched;
`endif

  int n_checks = 0;
  int n_errors = 0;

  instr_buffer #(.N(N), .DEPTH(DEPTH)) dut (
    .clock              (clock),
    .reset              (reset),
    .flush              (flush),
    .fetch_count        (fetch_count),
    .fetch_packets      (fetch_packets),
    .free_slots         (free_slots),
    .fetch_accept       (fetch_accept),
    .dispatch_window    (dispatch_window),
    .window_valid_count (window_valid_count),
    .dispatch_count     (dispatch_count)
`ifdef IBUF_PERF_EN
    ,
    .perf_empty_cycles  (perf_empty_cycles),
    .perf_full_stalls   (perf_full_stalls),
    .perf_dispatched    (perf_dispatched)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  function automatic FETCH_PACKET mk(input logic [31:0] pc);
    FETCH_PACKET p;
    p.pc   = pc;
    p.inst = pc ^ 32'hDEAD_BEEF;
    return p;
  endfunction

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic drive(input logic [31:0] pc0, input int fc, input int dc, input logic fl);
    for (int j = 0; j < N; j++) fetch_packets[j] = mk(pc0 + 32'(4 * j));
    fetch_count    = 2'(fc);
    dispatch_count = 2'(dc);
    flush          = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    fetch_count    = '0;
    dispatch_count = '0;
    flush          = 1'b0;
    fetch_packets  = '0;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    // Reset then idle
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    check("rst_wvc", 192'(window_valid_count), 192'(0));
    check("rst_free", 192'(free_slots), 192'(16));
    check("rst_window", 192'(dispatch_window), 192'(0));
    check("rst_accept_fc0", 192'(fetch_accept), 192'(0));

    // Fill: 5 groups of 3, then a rejected 6th, then a single accepted
    for (int k = 0; k < 5; k++) begin
      drive(32'h1000 + 32'(12 * k), 3, 0, 1'b0);
      check($sformatf("fill_accept%0d", k), 192'(fetch_accept), 192'(1));
      tick();
    end
    check("fill_free15", 192'(free_slots), 192'(1));
    check("fill_wvc", 192'(window_valid_count), 192'(3));
    check("fill_lane0", 192'(dispatch_window[0]), 192'(mk(32'h1000)));
    check("fill_lane2", 192'(dispatch_window[2]), 192'(mk(32'h1008)));
    drive(32'h2000, 3, 0, 1'b0);
    check("full_reject", 192'(fetch_accept), 192'(0));
    tick();
    check("full_hold", 192'(free_slots), 192'(1));
    drive(32'h3000, 1, 0, 1'b0);
    check("last_accept", 192'(fetch_accept), 192'(1));
    tick();
    check("full_free0", 192'(free_slots), 192'(0));

    // Wrap: move head/tail to 14, then push a group straddling 15->0
    do_reset();
    for (int k = 0; k < 14; k++) begin
      drive(32'h500 + 32'(4 * k), 1, 0, 1'b0);
      tick();
      drive(32'h0, 0, 1, 1'b0);
      tick();
    end
    check("wrap_empty", 192'(free_slots), 192'(16));
    drive(32'h100, 3, 0, 1'b0);
    tick();
    check("wrap_wvc", 192'(window_valid_count), 192'(3));
    check("wrap_lane0", 192'(dispatch_window[0]), 192'(mk(32'h100)));
    check("wrap_lane1", 192'(dispatch_window[1]), 192'(mk(32'h104)));
    check("wrap_lane2", 192'(dispatch_window[2]), 192'(mk(32'h108)));
    drive(32'h0, 0, 2, 1'b0);
    tick();
    check("wrap_pop_lane0", 192'(dispatch_window[0]), 192'(mk(32'h108)));
    check("wrap_pop_wvc", 192'(window_valid_count), 192'(1));
    check("wrap_pop_lane1", 192'(dispatch_window[1]), 192'(0));

    // Simultaneous push and pop at count=4
    do_reset();
    drive(32'hA00, 3, 0, 1'b0);
    tick();
    drive(32'hA0C, 1, 0, 1'b0);
    tick();
    check("sim_free12", 192'(free_slots), 192'(12));
    drive(32'hB00, 3, 3, 1'b0);
    check("sim_accept", 192'(fetch_accept), 192'(1));
    tick();
    check("sim_count4", 192'(free_slots), 192'(12));
    check("sim_lane0", 192'(dispatch_window[0]), 192'(mk(32'hA0C)));
    check("sim_lane1", 192'(dispatch_window[1]), 192'(mk(32'hB00)));
    check("sim_lane2", 192'(dispatch_window[2]), 192'(mk(32'hB04)));

    // Over-request: one entry, ask for three
    do_reset();
    drive(32'hC00, 1, 0, 1'b0);
    tick();
    check("over_wvc1", 192'(window_valid_count), 192'(1));
    drive(32'h0, 0, 3, 1'b0);
    tick();
    check("over_free16", 192'(free_slots), 192'(16));
    check("over_wvc0", 192'(window_valid_count), 192'(0));
    check("over_window", 192'(dispatch_window), 192'(0));

    // Flush with concurrent traffic at count=9
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(32'hD00 + 32'(12 * k), 3, 0, 1'b0);
      tick();
    end
    check("flush_pre_free7", 192'(free_slots), 192'(7));
    drive(32'hE00, 2, 3, 1'b1);
    check("flush_accept", 192'(fetch_accept), 192'(0));
    tick();
    check("flush_free16", 192'(free_slots), 192'(16));
    check("flush_wvc", 192'(window_valid_count), 192'(0));
    check("flush_window", 192'(dispatch_window), 192'(0));
    drive(32'hF00, 2, 0, 1'b0);
    tick();
    check("post_flush_wvc", 192'(window_valid_count), 192'(2));
    check("post_flush_lane0", 192'(dispatch_window[0]), 192'(mk(32'hF00)));
    check("post_flush_lane1", 192'(dispatch_window[1]), 192'(mk(32'hF04)));

    // Reset mid-operation beats concurrent traffic
    drive(32'h700, 3, 1, 1'b0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check("rprio_free16", 192'(free_slots), 192'(16));
    check("rprio_wvc", 192'(window_valid_count), 192'(0));
    check("rprio_window", 192'(dispatch_window), 192'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_buffer.md
Name: instr_buffer

Overview:
- Circular FIFO of FETCH_PACKETs between fetch and decode/dispatch.
- Absorbs up to `N fetched instructions per cycle.
- Presents the `N oldest entries as dispatch_window with window_valid_count to decode and stage_dispatch.
- Retires dispatch_count entries per cycle; flushes completely on a branch-mispredict recovery.

Parameters:
- N, `N, superscalar width: max enqueue and max dequeue per cycle.
- DEPTH, `IBUF_SZ (default 16), number of entries; power of two, DEPTH >= 2*N.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-low reset; asserted when 0, sampled on clock rising edge.
- flush  in  1  mispredict recovery; empties buffer at next edge.
- fetch_count  in  $clog2(N+1)  number of valid packets in fetch_packets this cycle, lanes 0..fetch_count-1.
- fetch_packets  in  N x FETCH_PACKET  packets from fetch, oldest in lane 0.
- free_slots  out  $clog2(DEPTH+1)  DEPTH minus registered occupancy; fetch must not send more than this.
- fetch_accept  out  1  this cycle's fetch_count packets are written.
- dispatch_window  out  N x FETCH_PACKET  oldest entries, lane 0 = head.
- window_valid_count  out  $clog2(N+1)  min(count, N).
- dispatch_count  in  $clog2(N+1)  entries consumed this cycle from the window head.

Behaviour:
- State:
  - head and tail pointers, $clog2(DEPTH) bits each, wrapping modulo DEPTH.
  - count register, $clog2(DEPTH+1) bits.
  - Entry array of DEPTH FETCH_PACKETs.
- Reset (reset==0 at edge): head=tail=count=0.
  - Outputs after reset: window_valid_count=0, free_slots=DEPTH, fetch_accept=0 whenever fetch_count=0, dispatch_window all '0.
  - Entry array contents need not be cleared.
- Window (combinational from registered state):
  - Lane i = mem[(head+i) mod DEPTH] for i < window_valid_count.
  - Lanes >= window_valid_count drive '0.
  - Zero-cycle latency from the register to the outputs.
- Dequeue:
  - pop = min(dispatch_count, window_valid_count); the clamp guards against an over-request.
  - head advances by pop, with wrap.
- Enqueue:
  - fetch_accept = (fetch_count <= free_slots) && !flush.
  - free_slots uses registered count only; same-cycle pops do not create space, which keeps the path fetch-to-dispatch free of combinational loops.
  - When accepted, lane j is written to mem[(tail+j) mod DEPTH] for j < fetch_count, and tail advances by fetch_count.
  - When not accepted, the whole group is rejected (no partial writes). Fetch holds and retries.
- count_next = count + push - pop.
  - Simultaneous push and pop in the same cycle are legal.
  - With count=DEPTH, pop=N, fetch_count=N: the push is rejected, count becomes DEPTH-N.
- Flush (reset==1, flush==1):
  - head=tail=count=0 at the edge.
  - The incoming fetch group is dropped and fetch_accept=0.
  - dispatch_count is ignored.
  - Flush takes priority over push and pop.
- Reset mid-operation overrides flush and all traffic.
- Invariants:
  - count <= DEPTH.
  - tail == (head + count) mod DEPTH.
- Wrap-around: a single push or pop group may straddle index DEPTH-1 to index 0.

Optional Feature:
- Macro: IBUF_PERF_EN.
- When defined, three extra output ports are added:
  - perf_empty_cycles (32b): cycles with count==0.
  - perf_full_stalls (32b): cycles with fetch_count>0 && !fetch_accept && !flush.
  - perf_dispatched (32b): sum of pop.
- Counter rules:
  - Counters saturate at 32'hFFFF_FFFF.
  - Cleared by reset.
  - Not cleared by flush.
- When undefined: the ports and counters are absent, with zero area and no other behavioural difference.

Decomposition:
- sys_defs.svh:
  - `IBUF_SZ constant.
  - IBUF_IDX typedef, logic [$clog2(`IBUF_SZ)-1:0].
  - IBUF_COUNT typedef, logic [$clog2(`IBUF_SZ+1)-1:0].
  - FETCH_PACKET, which already exists there.
- No sub-module: pointer and modulo math fit inline. The perf counters stay in an `ifdef block within this module.

Test Plan:
- Reset then idle; N=3, DEPTH=16:
  - window_valid_count=0, free_slots=16, dispatch_window all zero.
- Fill: 5 cycles of fetch_count=3 with dispatch_count=0, then a 6th:
  - count=15, free_slots=1.
  - 6th group (fetch_count=3) gives fetch_accept=0 and count stays 15.
  - Then fetch_count=1 is accepted and count=16.
- Wrap:
  - Preload head=14 via 14 push/pop cycles, push 3 packets with PCs 0x100, 0x104, 0x108.
  - Required window: lanes 0..2 show PCs 0x100/0x104/0x108 from indices 14,15,0.
  - dispatch_count=2 leaves lane 0 = 0x108.
- Simultaneous push and pop:
  - count=4, fetch_count=3, dispatch_count=3 gives count=4 next cycle.
  - New lane 0 is the old 4th entry.
- Over-request:
  - count=1, dispatch_count=3 gives pop=1, count=0 and no underflow.
- Flush with concurrent traffic, then reset priority:
  - count=9, flush=1, fetch_count=2, dispatch_count=3 gives count=0, fetch_accept=0, window_valid_count=0 next cycle.
  - With reset=0 and flush=0 in the same cycle, reset still clears all state.
